// File: rtl/rcas_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rcas_seq                                                          |
// | Brief   : Slice-serial ripple-carry adder/subtractor, valid/ready handshake |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rcas_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out
);

    localparam int              C_N    = WIDTH / SLICE;
    localparam int              C_CW   = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_op_a;
    logic [WIDTH-1:0]      r_op_b;
    logic [WIDTH-1:0]      r_acc;
    logic                  r_carry;
    logic [C_CW-1:0]       r_cnt;
    logic [SLICE:0]        w_sum;
    logic [WIDTH+SLICE-1:0] w_cat;
    logic [WIDTH-1:0]      w_acc_next;
    logic                  w_last;
    logic                  w_accept;

    // Operands shift right one slice per cycle; each new sum slice enters at the
    // top of the accumulator so the first slice ends up at the LSBs after N steps.
    assign w_sum      = {1'b0, r_op_a[SLICE-1:0]} + {1'b0, r_op_b[SLICE-1:0]}
                      + {{SLICE{1'b0}}, r_carry};
    assign w_cat      = {w_sum[SLICE-1:0], r_acc};
    assign w_acc_next = w_cat[WIDTH+SLICE-1:SLICE];
    assign w_last     = (r_cnt == C_LAST);
    assign w_accept   = (r_state == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            result  <= '0;
            c_out   <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= sel ? ~b : b;
            r_carry <= sel;
            r_cnt   <= '0;
        end else if (r_state == S_CALC) begin
            r_op_a  <= r_op_a >> SLICE;
            r_op_b  <= r_op_b >> SLICE;
            r_acc   <= w_acc_next;
            r_carry <= w_sum[SLICE];
            r_cnt   <= r_cnt + C_CW'(1);
            if (w_last) begin
                result <= w_acc_next;
                c_out  <= w_sum[SLICE];
            end
        end
    end

endmodule
`default_nettype wire
